// File: rtl/cpu_datapath.sv
// cpu_datapath: 16-bit 4-stage pipelined datapath (F/DC/EX/AC) steered entirely by external strobes.
module cpu_datapath (
   input  logic             clk,
   input  logic             reset,
   output logic [15:0]      o_pc_addr,
   input  logic [15:0]      i_pc_rddata,
   output logic [15:0]      o_ldst_addr,
   output logic [15:0]      o_ldst_wrdata,
   input  logic [15:0]      i_ldst_rddata,
   output logic [7:0][15:0] o_tb_regs,
   input  logic             ld_pc,
   input  logic [1:0]       pc_in_sel,
   input  logic [1:0]       pc_addr_sel,
   input  logic             ld_rx,
   input  logic             ld_ry,
   input  logic             ld_pc_dc,
   input  logic             ld_ir_dc,
   input  logic [1:0]       sel_alu_a,
   input  logic [1:0]       sel_alu_b,
   input  logic             addsub,
   input  logic             ld_alu_r,
   input  logic             ld_nz,
   input  logic             ld_pc_ex,
   input  logic             ld_ir_ex,
   input  logic             ld_pc_ac,
   input  logic             ld_ir_ac,
   input  logic             wr_en,
   input  logic [1:0]       sel_datain,
   output logic [15:0]      r_ir_dc,
   output logic [15:0]      r_ir_ex,
   output logic [15:0]      r_ir_ac,
   output logic             r_n,
   output logic             r_z
);
   logic [15:0] pc, pc_dc, pc_ex, pc_ac, rx_dc, ry_dc, alu_r, op_a_r, op_b_r;
   logic [7:0][15:0] regs;
   logic [15:0] alu_a, alu_b, alu_res, wb_data, pc_next, rx_val, ry_val;
   logic [2:0] dest, rx_idx, ry_idx;
   always_comb begin
      wb_data = sel_datain == 2'd0 ? alu_r :
                sel_datain == 2'd1 ? i_ldst_rddata :
                sel_datain == 2'd2 ? op_b_r : pc_ac;
      dest    = sel_datain == 2'd3 ? 3'd7 : r_ir_ac[7:5];
      alu_a   = sel_alu_a == 2'd0 ? rx_dc :
                sel_alu_a == 2'd1 ? pc_ex :
                sel_alu_a == 2'd2 ? alu_r : wb_data;
      alu_b   = sel_alu_b == 2'd0 ? ry_dc :
                sel_alu_b == 2'd1 ? {{8{r_ir_ex[15]}}, r_ir_ex[15:8]} :
                sel_alu_b == 2'd2 ? {{4{r_ir_ex[15]}}, r_ir_ex[15:5], 1'b0} : alu_r;
      alu_res = addsub ? alu_a - alu_b : alu_a + alu_b;
      o_pc_addr = pc_addr_sel == 2'd1 ? alu_res :
                  pc_addr_sel == 2'd2 ? alu_a : pc;
      pc_next = pc_in_sel == 2'd0 ? o_pc_addr + 16'd2 :
                pc_in_sel == 2'd1 ? alu_res :
                pc_in_sel == 2'd2 ? alu_a : o_pc_addr;
      rx_idx  = r_ir_dc[7:5];
      ry_idx  = r_ir_dc[10:8];
      // Write-through: a read of the register being written sees the new value
      rx_val  = (wr_en && dest == rx_idx) ? wb_data : regs[rx_idx];
      ry_val  = (wr_en && dest == ry_idx) ? wb_data : regs[ry_idx];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= '0;
         pc_dc   <= '0;
         pc_ex   <= '0;
         pc_ac   <= '0;
         r_ir_dc <= '0;
         r_ir_ex <= '0;
         r_ir_ac <= '0;
         rx_dc   <= '0;
         ry_dc   <= '0;
         alu_r   <= '0;
         op_a_r  <= '0;
         op_b_r  <= '0;
         r_n     <= 1'b0;
         r_z     <= 1'b0;
         regs    <= '0;
      end else begin
         if (ld_pc)    pc      <= pc_next;
         if (ld_ir_dc) r_ir_dc <= i_pc_rddata;
         if (ld_pc_dc) pc_dc   <= o_pc_addr + 16'd2;
         if (ld_rx)    rx_dc   <= rx_val;
         if (ld_ry)    ry_dc   <= ry_val;
         if (ld_pc_ex) pc_ex   <= pc_dc;
         if (ld_ir_ex) r_ir_ex <= r_ir_dc;
         if (ld_alu_r) begin
            alu_r  <= alu_res;
            op_a_r <= alu_a;
            op_b_r <= alu_b;
         end
         if (ld_nz) begin
            r_n <= alu_res[15];
            r_z <= alu_res == 16'd0;
         end
         if (ld_pc_ac) pc_ac   <= pc_ex;
         if (ld_ir_ac) r_ir_ac <= r_ir_ex;
         if (wr_en)    regs[dest] <= wb_data;
      end
   end
   assign o_ldst_addr   = op_b_r;
   assign o_ldst_wrdata = op_a_r;
   assign o_tb_regs     = regs;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed vectors with hand-computed expectations for cpu_datapath.
module tb_cpu_datapath;
   logic clk = 1'b0, reset;
   logic [15:0] o_pc_addr, i_pc_rddata, o_ldst_addr, o_ldst_wrdata, i_ldst_rddata;
   logic [7:0][15:0] tb_regs;
   logic ld_pc, ld_rx, ld_ry, ld_pc_dc, ld_ir_dc, addsub, ld_alu_r, ld_nz;
   logic ld_pc_ex, ld_ir_ex, ld_pc_ac, ld_ir_ac, wr_en;
   logic [1:0] pc_in_sel, pc_addr_sel, sel_alu_a, sel_alu_b, sel_datain;
   logic [15:0] r_ir_dc, r_ir_ex, r_ir_ac;
   logic r_n, r_z;
   int checks = 0, errors = 0;
   cpu_datapath dut (
      .clk(clk), .reset(reset), .o_pc_addr(o_pc_addr), .i_pc_rddata(i_pc_rddata),
      .o_ldst_addr(o_ldst_addr), .o_ldst_wrdata(o_ldst_wrdata), .i_ldst_rddata(i_ldst_rddata),
      .o_tb_regs(tb_regs), .ld_pc(ld_pc), .pc_in_sel(pc_in_sel), .pc_addr_sel(pc_addr_sel),
      .ld_rx(ld_rx), .ld_ry(ld_ry), .ld_pc_dc(ld_pc_dc), .ld_ir_dc(ld_ir_dc),
      .sel_alu_a(sel_alu_a), .sel_alu_b(sel_alu_b), .addsub(addsub), .ld_alu_r(ld_alu_r),
      .ld_nz(ld_nz), .ld_pc_ex(ld_pc_ex), .ld_ir_ex(ld_ir_ex), .ld_pc_ac(ld_pc_ac),
      .ld_ir_ac(ld_ir_ac), .wr_en(wr_en), .sel_datain(sel_datain),
      .r_ir_dc(r_ir_dc), .r_ir_ex(r_ir_ex), .r_ir_ac(r_ir_ac), .r_n(r_n), .r_z(r_z)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      {ld_pc, ld_rx, ld_ry, ld_pc_dc, ld_ir_dc, addsub, ld_alu_r, ld_nz} = '0;
      {ld_pc_ex, ld_ir_ex, ld_pc_ac, ld_ir_ac, wr_en} = '0;
      {pc_in_sel, pc_addr_sel, sel_alu_a, sel_alu_b, sel_datain} = '0;
   endtask
   initial begin
      idle();
      reset = 1'b1;
      i_pc_rddata = '0;
      i_ldst_rddata = '0;
      step();
      step();
      reset = 1'b0;
      step();
      check("rst_pc", o_pc_addr, 16'h0000);
      for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), tb_regs[i], 16'h0000);
      check("rst_ir_dc", r_ir_dc, 16'h0000);
      check("rst_ir_ex", r_ir_ex, 16'h0000);
      check("rst_ir_ac", r_ir_ac, 16'h0000);
      check("rst_nz", {14'd0, r_n, r_z}, 16'h0000);
      // Sequential fetch, then a stalled PC
      ld_pc = 1'b1;
      #1 check("pc0", o_pc_addr, 16'h0000);
      step();
      check("pc2", o_pc_addr, 16'h0002);
      step();
      check("pc4", o_pc_addr, 16'h0004);
      step();
      check("pc6", o_pc_addr, 16'h0006);
      ld_pc = 1'b0;
      step();
      check("pc_hold", o_pc_addr, 16'h0006);
      // Add immediate: R1 = R1 + 5
      idle();
      i_pc_rddata = 16'h0530;
      ld_ir_dc = 1'b1;
      ld_pc_dc = 1'b1;
      step();
      check("ir_dc", r_ir_dc, 16'h0530);
      idle();
      ld_rx = 1'b1;
      ld_ir_ex = 1'b1;
      ld_pc_ex = 1'b1;
      step();
      idle();
      sel_alu_b = 2'd1;
      ld_alu_r = 1'b1;
      ld_nz = 1'b1;
      ld_ir_ac = 1'b1;
      ld_pc_ac = 1'b1;
      step();
      check("add_n", {15'd0, r_n}, 16'd0);
      check("add_z", {15'd0, r_z}, 16'd0);
      check("add_opb", o_ldst_addr, 16'h0005);
      idle();
      wr_en = 1'b1;
      step();
      check("add_r1", tb_regs[1], 16'h0005);
      // Subtract R1 - R1
      idle();
      i_pc_rddata = 16'h0120;
      ld_ir_dc = 1'b1;
      step();
      idle();
      ld_rx = 1'b1;
      ld_ry = 1'b1;
      step();
      idle();
      addsub = 1'b1;
      ld_alu_r = 1'b1;
      ld_nz = 1'b1;
      pc_addr_sel = 2'd1;
      #1 check("sub_res", o_pc_addr, 16'h0000);
      step();
      check("sub_z", {15'd0, r_z}, 16'd1);
      check("sub_n", {15'd0, r_n}, 16'd0);
      // Forwarding: alu_r(0) - imm 1, then alu_r + alu_r
      idle();
      ld_ir_ex = 1'b1;
      step();
      idle();
      sel_alu_a = 2'd2;
      sel_alu_b = 2'd1;
      addsub = 1'b1;
      ld_alu_r = 1'b1;
      ld_nz = 1'b1;
      pc_addr_sel = 2'd1;
      #1 check("fwd_res", o_pc_addr, 16'hFFFF);
      step();
      check("fwd_n", {15'd0, r_n}, 16'd1);
      check("fwd_z", {15'd0, r_z}, 16'd0);
      sel_alu_b = 2'd3;
      addsub = 1'b0;
      #1 check("fwd2_res", o_pc_addr, 16'hFFFE);
      step();
      check("fwd2_opa", o_ldst_wrdata, 16'hFFFF);
      check("fwd2_opb", o_ldst_addr, 16'hFFFF);
      // Store operands via wb_data forward and imm8
      idle();
      i_pc_rddata = 16'h4040;
      ld_ir_dc = 1'b1;
      step();
      idle();
      ld_ir_ex = 1'b1;
      step();
      idle();
      i_ldst_rddata = 16'h1234;
      sel_datain = 2'd1;
      sel_alu_a = 2'd3;
      sel_alu_b = 2'd1;
      ld_alu_r = 1'b1;
      ld_ir_ac = 1'b1;
      step();
      check("st_addr", o_ldst_addr, 16'h0040);
      check("st_data", o_ldst_wrdata, 16'h1234);
      check("ir_ac", r_ir_ac, 16'h4040);
      // Load into R2 with same-cycle DC read of R2
      idle();
      i_ldst_rddata = 16'hBEEF;
      sel_datain = 2'd1;
      wr_en = 1'b1;
      ld_rx = 1'b1;
      step();
      idle();
      pc_addr_sel = 2'd2;
      #1 check("ld_r2", tb_regs[2], 16'hBEEF);
      check("wr_through", o_pc_addr, 16'hBEEF);
      // Branch/call: pc_ex=0x10, imm11=-4
      idle();
      ld_pc = 1'b1;
      repeat (4) step();
      check("pc_e", o_pc_addr, 16'h000E);
      idle();
      i_pc_rddata = 16'hFF80;
      ld_ir_dc = 1'b1;
      ld_pc_dc = 1'b1;
      step();
      idle();
      ld_pc_ex = 1'b1;
      ld_ir_ex = 1'b1;
      step();
      idle();
      ld_pc_ac = 1'b1;
      ld_ir_ac = 1'b1;
      sel_alu_a = 2'd1;
      sel_alu_b = 2'd2;
      pc_addr_sel = 2'd1;
      pc_in_sel = 2'd1;
      ld_pc = 1'b1;
      #1 check("br_addr", o_pc_addr, 16'h0008);
      step();
      idle();
      #1 check("br_pc", o_pc_addr, 16'h0008);
      check("br_ir_ac", r_ir_ac, 16'hFF80);
      sel_datain = 2'd3;
      wr_en = 1'b1;
      step();
      idle();
      check("link_r7", tb_regs[7], 16'h0010);
      check("link_r4", tb_regs[4], 16'h0000);
      step();
      check("hold_r1", tb_regs[1], 16'h0005);
      // Reset beats every strobe
      {ld_pc, ld_rx, ld_ry, ld_pc_dc, ld_ir_dc, ld_alu_r, ld_nz} = '1;
      {ld_pc_ex, ld_ir_ex, ld_pc_ac, ld_ir_ac, wr_en} = '1;
      reset = 1'b1;
      step();
      check("mrst_pc", o_pc_addr, 16'h0000);
      check("mrst_r2", tb_regs[2], 16'h0000);
      check("mrst_r7", tb_regs[7], 16'h0000);
      check("mrst_ir_dc", r_ir_dc, 16'h0000);
      check("mrst_n", {15'd0, r_n}, 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
